mips_dmem_ctrl: RTL and testbench
=================================

Name: mips_dmem_ctrl

Overview:
- Multi-cycle load/store unit downstream of the core's execute stage. Consumes the ALU-computed address, store data and access size.
- Drives a word-wide external data memory over a req/ack handshake with per-byte enables.
- Returns the aligned, sign/zero-extended load word to write-back.
- Asserts stall to freeze the PC and register-file write while an access is in flight.

Parameters:
- TIMEOUT_CYC, 16, max cycles waiting for mem_ack before abort (>=2)
- CNT_W, 5, width of the timeout counter (must hold TIMEOUT_CYC)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  core requests a load/store; held stable by core while stall=1
- req_write  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as misaligned)
- req_signed  in  1  loads only: 1=sign-extend (lb/lh), 0=zero-extend (lbu/lhu)
- req_addr  in  32  byte address (ALU result)
- req_wdata  in  32  store data from rt, right-justified
- stall  out  1  core must not advance PC or commit write-back
- rdata  out  32  formatted load data, valid in DONE cycle
- misalign_err  out  1  one-cycle pulse in DONE when the access was misaligned
- timeout_err  out  1  one-cycle pulse in DONE when mem_ack never arrived
- mem_req  out  1  external memory request
- mem_we  out  1  external write enable
- mem_be  out  4  byte enables, bit i = byte lane i (little-endian, lane 0 = addr[1:0]=00)
- mem_addr  out  32  word-aligned address {req_addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completion; mem_rdata valid same cycle for reads
- mem_rdata  in  32  raw read word

Behaviour:
- Reset (async) values: state=IDLE, counter=0, rdata=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, misalign_err=0, timeout_err=0.
- Reset mid-access drops mem_req immediately; late mem_ack after reset is ignored.
- stall = req_valid && (state != DONE), combinational.
- FSM states:
  - IDLE: on req_valid, check alignment.
    - Misaligned: half with addr[0]=1; word with addr[1:0]!=0; size=11. Go to DONE with the misalign flag set; no memory cycle issued.
    - Aligned: register mem_addr/mem_we/mem_be/mem_wdata, set mem_req=1, clear counter, go to ACCESS.
  - ACCESS: hold mem_req and all mem_* outputs stable.
    - On mem_ack: drop mem_req; for loads capture formatted data into rdata; go to DONE.
    - Else if counter==TIMEOUT_CYC-1: drop mem_req, rdata=0, set the timeout flag, go to DONE.
    - Else counter increments.
  - DONE: stall=0 for exactly one cycle; error pulses asserted here only; next state IDLE.
- Stores leave rdata unchanged. Back-to-back requests: the new request is accepted in the IDLE cycle following DONE.
- Latency: request seen in IDLE at cycle 0, mem_req high from cycle 1, ack at cycle k>=1, DONE at cycle k+1. Minimum 3 cycles per access.
- Byte enables: byte = 4'b0001<<addr[1:0]; half = addr[1]?1100:0011; word = 1111.
- Store data: byte replicated in all 4 lanes; half replicated in both halves; word as-is.
- Load formatting: shift mem_rdata right by 8*addr[1:0]; take the low 8/16/32 bits; extend per req_signed (ignored for word).
- mem_ack outside ACCESS is ignored.
- req_valid dropping while in ACCESS is a core protocol violation. The access still completes and is not cancelled.

Decomposition:
- Shared package mips_mem_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
  - FSM state encoding IDLE/ACCESS/DONE
  - lane-enable constants
- One combinational sub-module mips_load_align(raw word, offset, size, signed -> formatted word), reused by any future load path.

Test Plan:
- Aligned sw: addr=0x100, wdata=0xDEADBEEF, ack on 2nd ACCESS cycle -> mem_be=1111, mem_addr=0x100, mem_wdata=0xDEADBEEF, stall high 3 cycles then low 1 cycle.
- Byte loads: lb vs lbu at addr=0x203, mem_rdata=0x80FF7F01 -> lane 3=0x80; lb rdata=0xFFFFFF80, lbu rdata=0x00000080, mem_be=1000.
- Half load/store: sh addr=0x12, wdata=0x0000ABCD -> mem_be=1100, mem_wdata=0xABCDABCD; lh addr=0x12, mem_rdata=0x8001_0000 -> rdata=0xFFFF8001.
- Misaligned lw addr=0x101 -> mem_req never asserted, DONE in cycle 1, misalign_err pulse 1 cycle, stall low in that cycle.
- Timeout: mem_ack held 0 -> mem_req high exactly 16 cycles, then DONE with timeout_err=1, rdata=0; later ack ignored.
- Reset mid-access: assert reset in cycle 2 of ACCESS -> mem_req=0 and stall=0 immediately (asynchronous); after release a new lw at 0x0 completes normally.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared encodings and lane helpers for the MIPS data-memory path.
package mips_mem_pkg;

  // Access size encodings; 2'b11 is reserved and treated as misaligned.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  // Byte-lane enables, lane 0 = addr[1:0] == 2'b00.
  localparam logic [3:0] BE_LANE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_BYTE: be = BE_LANE0 << off;
      SZ_HALF: be = off[1] ? BE_HALF_HI : BE_HALF_LO;
      SZ_WORD: be = BE_WORD;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate store data so the selected lane(s) carry it regardless of offset.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] w;
    w = data;
    case (size)
      SZ_BYTE: w = {4{data[7:0]}};
      SZ_HALF: w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mips_load_align.sv
// Combinational load formatter: lane select plus sign/zero extension.
module mips_load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  assign shifted = raw_i >> {offset_i, 3'b000};

  // Pick the low byte/half of the shifted word and extend it.
  always_comb begin
    data_o = shifted;
    case (size_i)
      SZ_BYTE: data_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: data_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mips_dmem_ctrl.sv
// Multi-cycle load/store unit: req/ack memory handshake, alignment check,
// timeout abort and load formatting for write-back.
module mips_dmem_ctrl
  import mips_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        misalign_err,
  output logic        timeout_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mis_q, mis_d;
  logic        tmo_q, tmo_d;
  // Load formatting info captured at accept so a misbehaving core cannot
  // corrupt an in-flight load by changing its request inputs.
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;

  logic [31:0] load_word;

  mips_load_align u_load_align (
    .raw_i    (mem_rdata),
    .offset_i (off_q),
    .size_i   (size_q),
    .signed_i (sign_q),
    .data_o   (load_word)
  );

  // Reset is included so the core sees stall drop the instant reset hits.
  assign stall        = req_valid && (state_q != StDone) && !reset;
  assign rdata        = rdata_q;
  assign misalign_err = mis_q;
  assign timeout_err  = tmo_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_be       = mem_be_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;

  // Next-state and registered-output logic for the IDLE/ACCESS/DONE FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mis_d       = 1'b0;
    tmo_d       = 1'b0;
    off_d       = off_q;
    size_d      = size_q;
    sign_d      = sign_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (is_misaligned(req_size, req_addr[1:0])) begin
            mis_d   = 1'b1;
            state_d = StDone;
          end else begin
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_we_d    = req_write;
            mem_be_d    = byte_en(req_size, req_addr[1:0]);
            mem_wdata_d = store_lanes(req_size, req_wdata);
            mem_req_d   = 1'b1;
            cnt_d       = '0;
            off_d       = req_addr[1:0];
            size_d      = req_size;
            sign_d      = req_signed;
            state_d     = StAccess;
          end
        end
      end
      StAccess: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            rdata_d = load_word;
          end
          state_d = StDone;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          mem_req_d = 1'b0;
          rdata_d   = '0;
          tmo_d     = 1'b1;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mis_q       <= 1'b0;
      tmo_q       <= 1'b0;
      off_q       <= 2'b00;
      size_q      <= SZ_BYTE;
      sign_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mis_q       <= mis_d;
      tmo_q       <= tmo_d;
      off_q       <= off_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
    end
  end

endmodule

// File: tb/tb_mips_dmem_ctrl.sv
// Directed self-checking bench for mips_dmem_ctrl.
module tb_mips_dmem_ctrl;
  import mips_mem_pkg::*;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        misalign_err;
  logic        timeout_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_total = 0;
  int n_pass  = 0;

  mips_dmem_ctrl #(
    .TIMEOUT_CYC (16),
    .CNT_W       (5)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .rdata        (rdata),
    .misalign_err (misalign_err),
    .timeout_err  (timeout_err),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one cycle; sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  // Load with ack in the first ACCESS cycle; leaves the bench in the DONE cycle.
  task automatic load1(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] raw);
    issue(1'b0, sz, sg, a, 32'h0);
    step();
    mem_rdata = raw;
    mem_ack   = 1'b1;
    step();
    mem_ack = 1'b0;
  endtask

  initial begin
    int hi_cnt;
    int guard;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = SZ_WORD;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    #12;
    check("rst_rdata", rdata, 32'h0);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_be", {28'h0, mem_be}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_errs", {30'h0, misalign_err, timeout_err}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    step();
    reset = 1'b0;
    step();

    // Aligned sw, ack on the second ACCESS cycle.
    issue(1'b1, SZ_WORD, 1'b0, 32'h100, 32'hDEADBEEF);
    #1;
    check("sw_stall_c0", {31'h0, stall}, 32'h1);
    step();
    check("sw_req_c1", {31'h0, mem_req}, 32'h1);
    check("sw_we", {31'h0, mem_we}, 32'h1);
    check("sw_be", {28'h0, mem_be}, 32'hF);
    check("sw_addr", mem_addr, 32'h100);
    check("sw_wdata", mem_wdata, 32'hDEADBEEF);
    check("sw_stall_c1", {31'h0, stall}, 32'h1);
    step();
    check("sw_req_c2", {31'h0, mem_req}, 32'h1);
    check("sw_stall_c2", {31'h0, stall}, 32'h1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("sw_stall_done", {31'h0, stall}, 32'h0);
    check("sw_req_done", {31'h0, mem_req}, 32'h0);
    req_valid = 1'b0;
    step();

    // lb / lbu from lane 3.
    issue(1'b0, SZ_BYTE, 1'b1, 32'h203, 32'h0);
    step();
    check("lb_be", {28'h0, mem_be}, 32'h8);
    check("lb_addr", mem_addr, 32'h200);
    check("lb_we", {31'h0, mem_we}, 32'h0);
    mem_rdata = 32'h80FF7F01;
    mem_ack   = 1'b1;
    step();
    mem_ack = 1'b0;
    check("lb_rdata", rdata, 32'hFFFFFF80);
    req_valid = 1'b0;
    step();
    load1(SZ_BYTE, 1'b0, 32'h203, 32'h80FF7F01);
    check("lbu_rdata", rdata, 32'h00000080);
    req_valid = 1'b0;
    step();

    // sh to upper half; rdata must keep the previous load value.
    issue(1'b1, SZ_HALF, 1'b0, 32'h12, 32'h0000ABCD);
    step();
    check("sh_be", {28'h0, mem_be}, 32'hC);
    check("sh_wdata", mem_wdata, 32'hABCDABCD);
    check("sh_addr", mem_addr, 32'h10);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("sh_rdata_kept", rdata, 32'h00000080);
    req_valid = 1'b0;
    step();
    load1(SZ_HALF, 1'b1, 32'h12, 32'h80010000);
    check("lh_rdata", rdata, 32'hFFFF8001);
    req_valid = 1'b0;
    step();

    // Misaligned lw: no memory cycle, DONE next cycle.
    issue(1'b0, SZ_WORD, 1'b0, 32'h101, 32'h0);
    step();
    check("mis_err", {31'h0, misalign_err}, 32'h1);
    check("mis_stall", {31'h0, stall}, 32'h0);
    check("mis_req", {31'h0, mem_req}, 32'h0);
    req_valid = 1'b0;
    step();
    check("mis_pulse_end", {31'h0, misalign_err}, 32'h0);
    check("mis_req_after", {31'h0, mem_req}, 32'h0);

    // Timeout: no ack ever.
    issue(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0);
    hi_cnt = 0;
    guard  = 0;
    do begin
      step();
      if (mem_req) hi_cnt++;
      guard++;
    end while (stall && guard < 40);
    check("tmo_bound", {31'h0, (guard >= 40)}, 32'h0);
    check("tmo_req_cycles", hi_cnt, 32'd16);
    check("tmo_err", {31'h0, timeout_err}, 32'h1);
    check("tmo_rdata", rdata, 32'h0);
    req_valid = 1'b0;
    step();
    check("tmo_pulse_end", {31'h0, timeout_err}, 32'h0);
    mem_rdata = 32'h55AA55AA;
    mem_ack   = 1'b1;
    step();
    mem_ack = 1'b0;
    check("late_ack_req", {31'h0, mem_req}, 32'h0);
    check("late_ack_rdata", rdata, 32'h0);

    // Reset during the second ACCESS cycle.
    issue(1'b0, SZ_WORD, 1'b0, 32'h80, 32'h0);
    step();
    step();
    check("rst_mid_pre", {31'h0, mem_req}, 32'h1);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_req", {31'h0, mem_req}, 32'h0);
    check("rst_mid_stall", {31'h0, stall}, 32'h0);
    req_valid = 1'b0;
    step();
    reset   = 1'b0;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("rst_late_ack_req", {31'h0, mem_req}, 32'h0);
    check("rst_late_ack_stall", {31'h0, stall}, 32'h0);

    // lw at 0 after reset, then a back-to-back sb at 0x5 held through DONE.
    load1(SZ_WORD, 1'b0, 32'h0, 32'h12345678);
    check("lw0_rdata", rdata, 32'h12345678);
    check("lw0_stall_done", {31'h0, stall}, 32'h0);
    issue(1'b1, SZ_BYTE, 1'b0, 32'h5, 32'h0000005A);
    step();
    check("b2b_idle_stall", {31'h0, stall}, 32'h1);
    check("b2b_idle_req", {31'h0, mem_req}, 32'h0);
    step();
    check("b2b_req", {31'h0, mem_req}, 32'h1);
    check("b2b_be", {28'h0, mem_be}, 32'h2);
    check("b2b_addr", mem_addr, 32'h4);
    check("b2b_wdata", mem_wdata, 32'h5A5A5A5A);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("b2b_done_stall", {31'h0, stall}, 32'h0);
    check("b2b_rdata_kept", rdata, 32'h12345678);
    req_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
